// File: rtl/axi_engine_pkg.sv
// Shared AXI encodings and engine state type for the per-port read/write burst engines.
package axi_engine_pkg;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [1:0] LOCK_NORMAL   = 2'b00;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
    localparam logic [2:0] PROT_DEFAULT  = 3'b010;
    localparam logic [3:0] QOS_DEFAULT   = 4'b0000;
    localparam logic [3:0] REGION_DEFAULT = 4'b0000;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } engine_state_e;

    // AxSIZE for a full-width beat; anything wider than 256 bits is treated as 512.
    function automatic logic [2:0] axsize_f(input int unsigned dw);
        case (dw)
            64:      axsize_f = 3'b011;
            128:     axsize_f = 3'b100;
            256:     axsize_f = 3'b101;
            default: axsize_f = 3'b110;
        endcase
    endfunction

endpackage

// File: rtl/write_engine_if.sv
// AXI4 write-channel bundle (AW, W, B) between a burst engine and the memory port.
interface write_engine_if #(
    parameter int unsigned ADDR_WIDTH = 33,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ID_WIDTH   = 6,
    parameter int unsigned LEN_WIDTH  = 8
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  AWVALID;
    logic                  AWREADY;
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [ID_WIDTH-1:0]   AWID;
    logic [LEN_WIDTH-1:0]  AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic [1:0]            AWLOCK;
    logic [3:0]            AWCACHE;
    logic [2:0]            AWPROT;
    logic [3:0]            AWQOS;
    logic [3:0]            AWREGION;

    logic                  WVALID;
    logic                  WREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic [STRB_WIDTH-1:0] WSTRB;
    logic                  WLAST;

    logic                  BVALID;
    logic                  BREADY;
    logic [ID_WIDTH-1:0]   BID;
    logic [1:0]            BRESP;

    modport master (
        output AWVALID, AWADDR, AWID, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION,
        output WVALID, WDATA, WSTRB, WLAST, BREADY,
        input  AWREADY, WREADY, BVALID, BID, BRESP
    );

    modport slave (
        input  AWVALID, AWADDR, AWID, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION,
        input  WVALID, WDATA, WSTRB, WLAST, BREADY,
        output AWREADY, WREADY, BVALID, BID, BRESP
    );

endinterface

// File: rtl/write_engine.sv
// AXI4 write-burst initiator: one AW beat, burst+1 streamed W beats from the controller, then the B response.
module write_engine
    import axi_engine_pkg::*;
#(
    parameter int unsigned ENGINE_ID  = 0,
    parameter int unsigned ADDR_WIDTH = 33,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ID_WIDTH   = 6,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [LEN_WIDTH-1:0]  burst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  write_busy,
    output logic                  write_end,
    output logic                  write_err,
    write_engine_if.master        m_axi
);

    engine_state_e         state_q, state_d;
    logic                  awvalid_q, awvalid_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [LEN_WIDTH-1:0]  awlen_q, awlen_d;
    logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic                  bready_q, bready_d;
    logic                  busy_q, busy_d;
    logic                  end_q, end_d;
    logic                  err_q, err_d;

    logic in_data_c;
    logic w_hs_c;
    logic last_c;

    assign in_data_c = (state_q == DATA);
    assign last_c    = in_data_c && (beat_cnt_q == awlen_q);
    assign w_hs_c    = in_data_c && wr_valid && m_axi.WREADY;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            awvalid_q  <= 1'b0;
            awaddr_q   <= '0;
            awlen_q    <= '0;
            beat_cnt_q <= '0;
            bready_q   <= 1'b0;
            busy_q     <= 1'b0;
            end_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            awvalid_q  <= awvalid_d;
            awaddr_q   <= awaddr_d;
            awlen_q    <= awlen_d;
            beat_cnt_q <= beat_cnt_d;
            bready_q   <= bready_d;
            busy_q     <= busy_d;
            end_q      <= end_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        awvalid_d  = awvalid_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        beat_cnt_d = beat_cnt_q;
        bready_d   = bready_q;
        busy_d     = busy_q;
        end_d      = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A start coinciding with the write_end pulse is dropped; the controller retries next cycle.
                if (start && !end_q) begin
                    awaddr_d   = write_addr;
                    awlen_d    = burst;
                    awvalid_d  = 1'b1;
                    busy_d     = 1'b1;
                    beat_cnt_d = '0;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                if (m_axi.AWREADY) begin
                    awvalid_d = 1'b0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (w_hs_c) begin
                    beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                    if (last_c) begin
                        bready_d = 1'b1;
                        state_d  = RESP;
                    end
                end
            end
            RESP: begin
                if (m_axi.BVALID) begin
                    bready_d = 1'b0;
                    end_d    = 1'b1;
                    err_d    = m_axi.BRESP[1];
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // W channel is a zero-latency pass-through of the controller stream while in DATA.
    assign m_axi.WVALID = in_data_c && wr_valid;
    assign m_axi.WDATA  = wr_data;
    assign m_axi.WLAST  = last_c;
    assign m_axi.WSTRB  = '1;
    assign wr_ready     = in_data_c && m_axi.WREADY;

    assign m_axi.AWVALID  = awvalid_q;
    assign m_axi.AWADDR   = awaddr_q;
    assign m_axi.AWLEN    = awlen_q;
    assign m_axi.AWID     = ID_WIDTH'(ENGINE_ID);
    assign m_axi.AWSIZE   = axsize_f(DATA_WIDTH);
    assign m_axi.AWBURST  = BURST_INCR;
    assign m_axi.AWLOCK   = LOCK_NORMAL;
    assign m_axi.AWCACHE  = CACHE_DEFAULT;
    assign m_axi.AWPROT   = PROT_DEFAULT;
    assign m_axi.AWQOS    = QOS_DEFAULT;
    assign m_axi.AWREGION = REGION_DEFAULT;
    assign m_axi.BREADY   = bready_q;

    assign write_busy = busy_q;
    assign write_end  = end_q;
    assign write_err  = err_q;

endmodule

// File: tb/tb_write_engine.sv
// Directed bench for write_engine: AXI slave side and controller stream driven from one linear sequence.
module tb_write_engine;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [32:0]  write_addr;
    logic [7:0]   burst;
    logic [255:0] wr_data;
    logic         wr_valid;
    logic         wr_ready;
    logic         write_busy;
    logic         write_end;
    logic         write_err;

    int errors = 0;
    int checks = 0;

    write_engine_if #(.ADDR_WIDTH(33), .DATA_WIDTH(256), .ID_WIDTH(6), .LEN_WIDTH(8)) axi ();

    write_engine #(
        .ENGINE_ID(0), .ADDR_WIDTH(33), .DATA_WIDTH(256), .ID_WIDTH(6), .LEN_WIDTH(8)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .write_addr (write_addr),
        .burst      (burst),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .write_busy (write_busy),
        .write_end  (write_end),
        .write_err  (write_err),
        .m_axi      (axi.master)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [255:0] beat_word(input int unsigned i);
        beat_word = {4{64'hC0DE_0000_0000_0000 | 64'(i)}};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] wv_pat;
        logic [9:0] wr_pat;
        int unsigned exp_cnt;

        resetn = 1'b0; start = 1'b0; write_addr = '0; burst = '0;
        wr_data = '0; wr_valid = 1'b1;
        axi.AWREADY = 1'b0; axi.WREADY = 1'b1; axi.BVALID = 1'b0; axi.BID = '0; axi.BRESP = 2'b00;
        #3;
        chk1("rst_awvalid", axi.AWVALID, 1'b0);
        chk1("rst_bready", axi.BREADY, 1'b0);
        chk1("rst_busy", write_busy, 1'b0);
        chk1("rst_end", write_end, 1'b0);
        chk1("rst_err", write_err, 1'b0);
        chk1("rst_wvalid", axi.WVALID, 1'b0);
        chk1("rst_wr_ready", wr_ready, 1'b0);
        chk1("rst_wlast", axi.WLAST, 1'b0);
        chkw("rst_awaddr", 256'(axi.AWADDR), 256'h0);
        chkw("rst_awlen", 256'(axi.AWLEN), 256'h0);
        chkw("awsize", 256'(axi.AWSIZE), 256'h5);
        chkw("awburst", 256'(axi.AWBURST), 256'h1);
        chkw("awcache", 256'(axi.AWCACHE), 256'h3);
        chkw("awprot", 256'(axi.AWPROT), 256'h2);
        chkw("awid", 256'(axi.AWID), 256'h0);
        chkw("wstrb", 256'(axi.WSTRB), 256'hFFFF_FFFF);
        #4 resetn = 1'b1;
        tick();

        // Single beat, slave always ready.
        start = 1'b1; write_addr = 33'h1000; burst = 8'd0;
        axi.AWREADY = 1'b1; axi.WREADY = 1'b1; axi.BVALID = 1'b1; axi.BRESP = 2'b00;
        wr_valid = 1'b1; wr_data = 256'h1111;
        #1 chk1("t1_idle_wvalid", axi.WVALID, 1'b0);
        tick(); start = 1'b0;
        #1;
        chk1("t1_awvalid", axi.AWVALID, 1'b1);
        chkw("t1_awaddr", 256'(axi.AWADDR), 256'h1000);
        chkw("t1_awlen", 256'(axi.AWLEN), 256'h0);
        chk1("t1_busy", write_busy, 1'b1);
        chk1("t1_no_w_before_aw", axi.WVALID, 1'b0);
        tick();
        chk1("t1_awvalid_drop", axi.AWVALID, 1'b0);
        chk1("t1_wvalid", axi.WVALID, 1'b1);
        chk1("t1_wlast", axi.WLAST, 1'b1);
        chkw("t1_wdata", axi.WDATA, 256'h1111);
        chk1("t1_wr_ready", wr_ready, 1'b1);
        tick();
        chk1("t1_bready", axi.BREADY, 1'b1);
        chk1("t1_resp_wvalid", axi.WVALID, 1'b0);
        chk1("t1_end_early", write_end, 1'b0);
        tick();
        chk1("t1_end", write_end, 1'b1);
        chk1("t1_err", write_err, 1'b0);
        chk1("t1_busy_clr", write_busy, 1'b0);
        chk1("t1_bready_clr", axi.BREADY, 1'b0);
        axi.BVALID = 1'b0; wr_valid = 1'b0;
        tick();
        chk1("t1_end_one_cycle", write_end, 1'b0);

        // Four beats with WREADY toggling and controller gaps.
        start = 1'b1; write_addr = 33'h2000; burst = 8'd3;
        tick(); start = 1'b0;
        tick();
        wv_pat = 10'b11_1011_1101;   // bit j = wr_valid in DATA cycle j
        wr_pat = 10'b11_1101_0101;   // bit j = WREADY in DATA cycle j
        exp_cnt = 0;
        for (int j = 0; j < 10 && exp_cnt < 4; j++) begin
            wr_valid = wv_pat[j]; axi.WREADY = wr_pat[j]; wr_data = beat_word(exp_cnt);
            #1;
            chk1("t2_wvalid", axi.WVALID, wv_pat[j]);
            chk1("t2_wr_ready", wr_ready, wr_pat[j]);
            chk1("t2_wlast", axi.WLAST, exp_cnt == 3);
            if (wv_pat[j]) chkw("t2_wdata", axi.WDATA, beat_word(exp_cnt));
            if (wv_pat[j] && wr_pat[j]) exp_cnt++;
            tick();
        end
        wr_valid = 1'b1; axi.WREADY = 1'b1;
        #1;
        chk1("t2_bready", axi.BREADY, 1'b1);
        chk1("t2_no_extra_beat", axi.WVALID, 1'b0);
        tick();
        chk1("t2_bready_held", axi.BREADY, 1'b1);
        chk1("t2_end_wait", write_end, 1'b0);
        axi.BVALID = 1'b1; axi.BRESP = 2'b01;
        tick();
        chk1("t2_end", write_end, 1'b1);
        chk1("t2_exokay_err", write_err, 1'b0);
        axi.BVALID = 1'b0; wr_valid = 1'b0;
        tick();
        chk1("t2_end_clr", write_end, 1'b0);

        // AWREADY stalled for five cycles, then SLVERR response.
        axi.AWREADY = 1'b0; start = 1'b1; write_addr = 33'h1_2345_6780; burst = 8'd1;
        wr_valid = 1'b1; wr_data = 256'hE0;
        tick(); start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk1("t3_awvalid_stable", axi.AWVALID, 1'b1);
            chkw("t3_awaddr_stable", 256'(axi.AWADDR), 256'h1_2345_6780);
            chkw("t3_awlen_stable", 256'(axi.AWLEN), 256'h1);
            chk1("t3_no_wvalid", axi.WVALID, 1'b0);
            chk1("t3_no_wr_ready", wr_ready, 1'b0);
            tick();
        end
        axi.AWREADY = 1'b1;
        tick();
        #1;
        chk1("t3_beat0_wvalid", axi.WVALID, 1'b1);
        chk1("t3_beat0_wlast", axi.WLAST, 1'b0);
        tick();
        wr_data = 256'hE1;
        #1;
        chk1("t3_beat1_wlast", axi.WLAST, 1'b1);
        chkw("t3_beat1_wdata", axi.WDATA, 256'hE1);
        tick();
        wr_valid = 1'b0; axi.BVALID = 1'b1; axi.BRESP = 2'b10;
        #1 chk1("t4_bready", axi.BREADY, 1'b1);
        tick();
        chk1("t4_end", write_end, 1'b1);
        chk1("t4_err", write_err, 1'b1);
        axi.BVALID = 1'b0;
        tick();
        chk1("t4_end_clr", write_end, 1'b0);
        chk1("t4_err_clr", write_err, 1'b0);

        // start during DATA and on the write_end cycle is ignored.
        start = 1'b1; write_addr = 33'h3000; burst = 8'd0;
        axi.WREADY = 1'b0; axi.BRESP = 2'b00; wr_valid = 1'b1; wr_data = 256'hF0;
        tick(); start = 1'b0;
        tick();
        start = 1'b1; write_addr = 33'h4000; burst = 8'd5;
        #1 chk1("t5_in_data_wvalid", axi.WVALID, 1'b1);
        tick(); start = 1'b0;
        #1;
        chk1("t5_data_start_ign", axi.AWVALID, 1'b0);
        chkw("t5_awaddr_kept", 256'(axi.AWADDR), 256'h3000);
        chk1("t5_still_data", axi.WVALID, 1'b1);
        axi.WREADY = 1'b1;
        tick();
        wr_valid = 1'b0; axi.BVALID = 1'b1;
        tick();
        axi.BVALID = 1'b0; start = 1'b1; write_addr = 33'h5000; burst = 8'd7;
        #1 chk1("t5_end", write_end, 1'b1);
        tick();
        chk1("t5_end_start_ign", axi.AWVALID, 1'b0);
        chk1("t5_end_busy", write_busy, 1'b0);
        tick(); start = 1'b0;
        chk1("t5_retry_awvalid", axi.AWVALID, 1'b1);
        chkw("t5_retry_awaddr", 256'(axi.AWADDR), 256'h5000);
        chkw("t5_retry_awlen", 256'(axi.AWLEN), 256'h7);

        // Reset after two beats of an eight-beat burst.
        tick();
        wr_valid = 1'b1; wr_data = 256'hAB;
        tick();
        tick();
        #1 chk1("t6_midburst_wvalid", axi.WVALID, 1'b1);
        resetn = 1'b0;
        #1;
        chk1("t6_rst_awvalid", axi.AWVALID, 1'b0);
        chk1("t6_rst_bready", axi.BREADY, 1'b0);
        chk1("t6_rst_busy", write_busy, 1'b0);
        chk1("t6_rst_wvalid", axi.WVALID, 1'b0);
        chk1("t6_rst_wr_ready", wr_ready, 1'b0);
        chkw("t6_rst_awaddr", 256'(axi.AWADDR), 256'h0);
        chkw("t6_rst_awlen", 256'(axi.AWLEN), 256'h0);
        tick();
        tick();
        chk1("t6_no_end", write_end, 1'b0);
        chk1("t6_no_err", write_err, 1'b0);
        resetn = 1'b1; wr_valid = 1'b0;
        tick();
        start = 1'b1; write_addr = 33'h6000; burst = 8'd0;
        tick(); start = 1'b0;
        chk1("t6_fresh_awvalid", axi.AWVALID, 1'b1);
        chkw("t6_fresh_awaddr", 256'(axi.AWADDR), 256'h6000);
        tick();
        wr_valid = 1'b1; wr_data = 256'h66;
        #1;
        chk1("t6_fresh_wvalid", axi.WVALID, 1'b1);
        chk1("t6_fresh_wlast", axi.WLAST, 1'b1);
        tick();
        wr_valid = 1'b0; axi.BVALID = 1'b1;
        tick();
        chk1("t6_fresh_end", write_end, 1'b1);
        chk1("t6_fresh_err", write_err, 1'b0);
        axi.BVALID = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
